mul16_seq: RTL and testbench
============================

// Module: mul16_seq
// PURPOSE
//  Sequential 16x16 multiplier for the calculator datapath; feeds the existing 8x8 combinational
//  Wallace array one byte-pair per cycle and accumulates its 16-bit products into a 32-bit result.
//  Sits between the operand/decode stage (start + operands) and the HI/LO result registers.
//  Supports unsigned (MULTU-style) and signed (MULT-style) operation via sign-magnitude correction.
// PARAMETERS
//  SIGNED_EN  1  1: signed_op honoured; 0: signed_op ignored, all operations unsigned
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   request; sampled only when busy=0
//  signed_op  in   1   1: a,b are two's complement; sampled with start
//  a          in   16  multiplicand; sampled with start
//  b          in   16  multiplier; sampled with start
//  busy       out  1   operation in progress; start ignored while high
//  done       out  1   one-cycle pulse: hi/lo hold the new product
//  hi         out  16  product bits [31:16]
//  lo         out  16  product bits [15:0]
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, busy=0, done=0, hi=lo=0, accumulator=0. Reset
//    mid-operation aborts it: no done pulse, hi/lo forced to 0 on the following cycle.
//  - States: IDLE -> MUL (4 steps) -> FIN -> IDLE.
//  - IDLE: start=1 at cycle T -> latch |a|,|b| (magnitude if signed_op&SIGNED_EN and sign bit set,
//    else raw), neg = sign(a)^sign(b) (0 if unsigned), acc=0, step=0, go MUL. busy=1 from T+1.
//  - MUL, cycles T+1..T+4: step k selects byte pair (i,j) = (0,0),(1,0),(0,1),(1,1);
//    acc += {16'b0, P} << 8*(i+j), P = 8x8 array output. Width 32, no overflow possible.
//  - FIN, cycle T+5: {hi,lo} <= neg ? -acc : acc (two's complement, 32-bit); -0 yields 0.
//  - Cycle T+6: state IDLE, busy=0, done=1 for exactly this cycle. Latency start->done = 6.
//  - start=1 in the done cycle is accepted (back-to-back, throughput 1 op / 6 cycles).
//  - start while busy=1: ignored entirely; operands and in-flight result unaffected.
//  - hi/lo change only at FIN (and reset); they hold the last product between operations.
//  - Boundaries: |0x8000| = 0x8000 fits 16-bit magnitude; 0x8000*0x8000 signed = 0x4000_0000;
//    0xFFFF*0xFFFF unsigned = 0xFFFE_0001 (max result, no carry out of bit 31).
//  - Operand registers are not updated after capture; changing a/b/signed_op while busy has no effect.
// STRUCTURE
//  - Shared package (calc_pkg): state encoding (IDLE, MUL, FIN), MUL_STEPS=4, byte-pair select table.
//  - One sub-module: a single instance of the existing 8x8 Wallace multiplier (module wallace),
//    byte operands muxed from the latched magnitudes by step; its 16-bit output added combinationally
//    into the accumulator register. Everything else (FSM, step counter, sign fix) lives in mul16_seq.
// TESTING
//  - Unsigned 0x1234*0x5678, start at T -> done=1 at T+6 only, {hi,lo}=0x0626_0060, busy T+1..T+5.
//  - Unsigned 0xFFFF*0xFFFF -> {hi,lo}=0xFFFE_0001; signed same operands -> 0x0000_0001.
//  - Signed 0xFFFF*0x0002 -> 0xFFFF_FFFE; signed 0x8000*0x8000 -> 0x4000_0000; signed 0x0000*0xFFFF -> 0.
//  - start with 0x0003*0x0004, then start at T+2 with 0x00FF*0x00FF -> ignored; done at T+6, result 0x0000_000C.
//  - reset asserted at T+3 of 0x1234*0x5678 -> busy=0, hi=lo=0 from T+4, no done; new start then yields correct result.
//  - start in done cycle with 0x0010*0x0010 -> accepted, second done exactly 6 cycles later, {hi,lo}=0x0000_0100.
//  - SIGNED_EN=0: signed_op=1, 0xFFFF*0x0002 -> 0x0001_FFFE (unsigned result).

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: FSM encoding,
// step count and the byte-pair schedule used to drive the 8x8 array.
package mul16_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int MUL_STEPS = 4;
  localparam int STEP_W    = $clog2(MUL_STEPS);

  // Which byte of each magnitude feeds the 8x8 array in a given step.
  typedef struct packed {
    logic hi_a;
    logic hi_b;
  } pair_t;

  // Step order (i,j) = (0,0),(1,0),(0,1),(1,1): low partial product first.
  function automatic pair_t pair_sel(input logic [STEP_W-1:0] step);
    pair_t p;
    case (step)
      2'd0:    p = '{hi_a: 1'b0, hi_b: 1'b0};
      2'd1:    p = '{hi_a: 1'b1, hi_b: 1'b0};
      2'd2:    p = '{hi_a: 1'b0, hi_b: 1'b1};
      2'd3:    p = '{hi_a: 1'b1, hi_b: 1'b1};
      default: p = '{hi_a: 1'b0, hi_b: 1'b0};
    endcase
    return p;
  endfunction

  // Left shift applied to a partial product: 8*(i+j), i.e. 0, 8 or 16.
  function automatic logic [4:0] pair_shift(input pair_t p);
    return {p.hi_a & p.hi_b, p.hi_a ^ p.hi_b, 3'b000};
  endfunction

  // Magnitude of a 16-bit value; 0x8000 maps to 0x8000, which is still
  // the correct unsigned magnitude.
  function automatic logic [15:0] mag16(input logic [15:0] v, input logic en);
    return (en && v[15]) ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/mul16_seq_if.sv
// Request/result bundle between the decode stage and the multiplier.
//
// Handshake: start is a request qualified by busy==0 in the same cycle;
// a, b and signed_op are captured only on that accepted cycle. There is
// no back-pressure on the result: done pulses for one cycle when hi/lo
// hold the new product, and hi/lo then hold until the next product.
interface mul16_seq_if;
  import mul16_seq_pkg::*;

  logic        start;
  logic        signed_op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul16_seq_wallace.sv
// 8x8 unsigned combinational Wallace-tree multiplier. Eight partial
// product rows are reduced with 3:2 carry-save stages down to two rows,
// then a single carry-propagate add produces the 16-bit product. All
// rows are kept 16 bits wide; the true product never exceeds 16 bits so
// nothing meaningful is lost to truncation.
module wallace (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] p
);

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // 3:2 compressor on whole rows: returns {carry_row, sum_row}.
  function automatic logic [31:0] csa(input logic [15:0] u,
                                      input logic [15:0] v,
                                      input logic [15:0] w);
    logic [15:0] s;
    logic [15:0] c;
    s = u ^ v ^ w;
    c = ((u & v) | (u & w) | (v & w)) << 1;
    return {c, s};
  endfunction

  // Partial products: row r is x shifted by r, gated by y[r].
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      pp[r] = y[r] ? ({8'b0, x} << r) : 16'd0;
    end
  end

  // Reduction tree 8 -> 6 -> 4 -> 3 -> 2 rows, then final add.
  always_comb begin
    {c0, s0} = csa(pp[0], pp[1], pp[2]);
    {c1, s1} = csa(pp[3], pp[4], pp[5]);
    {c2, s2} = csa(s0, c0, s1);
    {c3, s3} = csa(c1, pp[6], pp[7]);
    {c4, s4} = csa(s2, c2, s3);
    {c5, s5} = csa(s4, c4, c3);
    p        = s5 + c5;
  end

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 multiplier. Operand magnitudes are latched on start,
// the 8x8 array is fed one byte pair per cycle for four cycles, the
// shifted partial products accumulate into a 32-bit register, and the
// sign is restored in one final cycle before done pulses.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mul16_seq_if.slave    bus,
  output state_t        dbg_state
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [15:0]         mag_a;
  logic [15:0]         mag_b;
  logic                neg;
  logic [31:0]         acc;
  logic [31:0]         prod_q;
  logic                busy_q;
  logic                done_q;

  pair_t               pair;
  logic [7:0]          byte_a;
  logic [7:0]          byte_b;
  logic [15:0]         pp;
  logic [31:0]         acc_sum;
  logic [31:0]         acc_fixed;
  logic                sgn;

  // Signed interpretation only when the build allows it.
  assign sgn = SIGNED_EN & bus.signed_op;

  // Byte selection for the current step and the accumulate/sign-fix paths.
  always_comb begin
    pair      = pair_sel(step);
    byte_a    = pair.hi_a ? mag_a[15:8] : mag_a[7:0];
    byte_b    = pair.hi_b ? mag_b[15:8] : mag_b[7:0];
    acc_sum   = acc + ({16'b0, pp} << pair_shift(pair));
    acc_fixed = neg ? (~acc + 32'd1) : acc;
  end

  wallace u_wallace (
    .x (byte_a),
    .y (byte_b),
    .p (pp)
  );

  // Control FSM with operand capture, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      step   <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      prod_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mag_a  <= mag16(bus.a, sgn);
            mag_b  <= mag16(bus.b, sgn);
            neg    <= sgn & (bus.a[15] ^ bus.b[15]);
            acc    <= '0;
            step   <= '0;
            state  <= ST_MUL;
            busy_q <= 1'b1;
          end
        end
        ST_MUL: begin
          acc  <= acc_sum;
          step <= step + STEP_W'(1);
          if (step == LAST_STEP) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          prod_q <= acc_fixed;
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = prod_q[31:16];
  assign bus.lo    = prod_q[15:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_mul16_seq.sv
// Bench for mul16_seq: two instances (signed enabled / disabled) share the
// same stimulus; a vector table, hand-written timing sequences and random
// operands are checked against a plain-arithmetic reference product.
module tb_mul16_seq;
  import mul16_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul16_seq_if bus1 ();
  mul16_seq_if bus0 ();
  state_t dbg1;
  state_t dbg0;

  mul16_seq #(.SIGNED_EN(1'b1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1.slave),
    .dbg_state (dbg1)
  );

  mul16_seq #(.SIGNED_EN(1'b0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0.slave),
    .dbg_state (dbg0)
  );

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  logic [31:0] exp_q [$];
  logic [31:0] exp0_q [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference product from the arithmetic definition, not the datapath.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic en);
    longint pa;
    longint pb;
    if (s && en) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({48'b0, a});
      pb = longint'({48'b0, b});
    end
    return 32'(pa * pb);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic st, input logic [15:0] a, input logic [15:0] b,
                            input logic s);
    bus1.start = st; bus1.a = a; bus1.b = b; bus1.signed_op = s;
    bus0.start = st; bus0.a = a; bus0.b = b; bus0.signed_op = s;
  endtask

  task automatic push_exp(input logic [31:0] e1, input logic [31:0] e0);
    exp_q.push_back(e1);
    exp0_q.push_back(e0);
  endtask

  // Called at the negedge of the start cycle T (start already driven).
  // Advances cycle by cycle until done or a 20-cycle budget; optionally
  // raises a stray start (0xFF*0xFF signed) in cycle T+intrude.
  task automatic wait_done(input string name, input int intrude);
    int lat;
    bit busy_ok;
    logic [31:0] e1;
    logic [31:0] e0;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == intrude) set_inputs(1'b1, 16'h00FF, 16'h00FF, 1'b1);
      else                set_inputs(1'b0, 16'h0000, 16'h0000, 1'b0);
      if (!bus1.done && (bus1.busy !== 1'b1 || bus0.busy !== 1'b1)) busy_ok = 1'b0;
    end while (!bus1.done && lat < 20);
    check32({name, "_latency"}, 32'(lat), 32'd6);
    check32({name, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
    check32({name, "_done_cycle_flags"}, {28'b0, bus1.busy, bus0.busy, bus1.done, bus0.done},
            32'b0011);
    e1 = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hDEAD_BEEF;
    check32({name, "_prod_s1"}, {bus1.hi, bus1.lo}, e1);
    check32({name, "_prod_s0"}, {bus0.hi, bus0.lo}, e0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp1;
    logic [31:0] exp0;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int seen_done;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [31:0] last;

    vecs[0] = '{"u_1234x5678",   16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 32'h0626_0060};
    vecs[1] = '{"u_ffffxffff",   16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 32'hFFFE_0001};
    vecs[2] = '{"s_ffffxffff",   16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 32'hFFFE_0001};
    vecs[3] = '{"s_ffffx0002",   16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE, 32'h0001_FFFE};
    vecs[4] = '{"s_8000x8000",   16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 32'h4000_0000};
    vecs[5] = '{"s_0000xffff",   16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{"s_7fffx8000",   16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 32'h3FFF_8000};
    vecs[7] = '{"s_0010x0010",   16'h0010, 16'h0010, 1'b1, 32'h0000_0100, 32'h0000_0100};

    checks = 0;
    failures = 0;
    set_inputs(1'b0, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check32("reset_flags", {28'b0, bus1.busy, bus1.done, bus0.busy, bus0.done}, 32'd0);
    check32("reset_prod_s1", {bus1.hi, bus1.lo}, 32'd0);
    check32("reset_prod_s0", {bus0.hi, bus0.lo}, 32'd0);
    check32("reset_state", {28'b0, dbg1, dbg0}, {28'b0, ST_IDLE, ST_IDLE});

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_inputs(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      push_exp(vecs[i].exp1, vecs[i].exp0);
      wait_done(vecs[i].name, 0);
    end

    // Result holds after the done pulse.
    @(negedge clk);
    check32("hold_after_done", {15'b0, bus1.done, bus1.hi, bus1.lo} & 32'hFFFF_FFFF,
            {15'b0, 1'b0, 16'h0000} | 32'h0000_0100);

    // Start while busy (cycle T+2) is ignored.
    @(negedge clk);
    set_inputs(1'b1, 16'h0003, 16'h0004, 1'b0);
    push_exp(32'h0000_000C, 32'h0000_000C);
    wait_done("ignored_start", 2);

    // Reset in cycle T+3 aborts the operation.
    @(negedge clk);
    set_inputs(1'b1, 16'h1234, 16'h5678, 1'b0);
    @(negedge clk); set_inputs(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check32("abort_busy", {30'b0, bus1.busy, bus0.busy}, 32'd0);
    check32("abort_prod_s1", {bus1.hi, bus1.lo}, 32'd0);
    check32("abort_state", {30'b0, dbg1}, {30'b0, ST_IDLE});
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus1.done || bus0.done) seen_done++;
      @(negedge clk);
    end
    check32("abort_no_done", 32'(seen_done), 32'd0);
    set_inputs(1'b1, 16'h1234, 16'h5678, 1'b0);
    push_exp(32'h0626_0060, 32'h0626_0060);
    wait_done("after_abort", 0);

    // Back-to-back: start again in the done cycle.
    @(negedge clk);
    set_inputs(1'b1, 16'hFFFF, 16'h0002, 1'b1);
    push_exp(32'hFFFF_FFFE, 32'h0001_FFFE);
    wait_done("b2b_first", 0);
    set_inputs(1'b1, 16'h0010, 16'h0010, 1'b0);
    push_exp(32'h0000_0100, 32'h0000_0100);
    wait_done("b2b_second", 0);

    // Randomised operands against the reference model.
    last = 32'h0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'h8000;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 16'h8000;
        1:       rb = 16'h0000;
        default: rb = 16'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      @(negedge clk);
      set_inputs(1'b1, ra, rb, rs);
      push_exp(model(ra, rb, rs, 1'b1), model(ra, rb, rs, 1'b0));
      last = model(ra, rb, rs, 1'b1);
      wait_done($sformatf("rand%0d", i), 0);
    end

    // Inputs changing while idle do not disturb the held result.
    @(negedge clk);
    set_inputs(1'b0, 16'hAAAA, 16'h5555, 1'b1);
    @(negedge clk);
    check32("idle_hold", {bus1.hi, bus1.lo}, last);

    check32("queues_drained", 32'(exp_q.size() + exp0_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
